// File: rtl/inst_queue_pkg.sv
// Shared types and sizing for the fetch-to-rename instruction queue.
package inst_queue_pkg;

    localparam int IQ_DEPTH  = 16;
    localparam int IQ_DATA_W = 32;

    typedef struct packed {
        logic [31:0]          pc;
        logic [IQ_DATA_W-1:0] inst;
    } fetch_packet_t;

endpackage

// File: rtl/inst_queue.sv
// In-order {pc, inst} queue between fetch and rename; circular buffer with wrap-bit pointers.
// Latency: a packet written at edge N is visible on out_* the cycle after; no bypass.
// Backpressure: in_ready = !full from registered state only; flush wins over any same-cycle handshake.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int  DEPTH      = IQ_DEPTH,
    parameter int  DATA_WIDTH = IQ_DATA_W,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic [31:0]           in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [31:0]           out_pc,
    output logic [PTR_W:0]        count
);

    typedef struct packed {
        logic [31:0]           pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         rd_entry;
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;
    logic           full, empty, enq, deq;

    always_comb begin
        empty  = (head_q == tail_q);
        full   = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);
        enq    = in_valid && !full && !flush;
        deq    = out_ready && !empty && !flush;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (enq) tail_d = tail_q + (PTR_W+1)'(1);
            if (deq) head_d = head_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is deliberately not reset; out_* are only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q[PTR_W-1:0]] <= '{pc: in_pc, inst: in_inst};
    end

    assign rd_entry  = mem_q[head_q[PTR_W-1:0]];
    assign out_pc    = rd_entry.pc;
    assign out_inst  = rd_entry.inst;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = tail_q - head_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed and random stimulus for inst_queue, checked against a queue-based reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = IQ_DEPTH;
    localparam int PW    = $clog2(DEPTH);

    logic                 clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IQ_DATA_W-1:0] in_inst, out_inst;
    logic [31:0]          in_pc, out_pc;
    logic [PW:0]          count;

    int errors = 0;
    int checks = 0;
    fetch_packet_t mq[$];

    inst_queue #(.DEPTH(IQ_DEPTH), .DATA_WIDTH(IQ_DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 64'(count), 64'(mq.size()));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
        if (mq.size() != 0) begin
            check({tag, ".out_pc"}, 64'(out_pc), 64'(mq[0].pc));
            check({tag, ".out_inst"}, 64'(out_inst), 64'(mq[0].inst));
        end
    endtask

    // One clock: model decides handshakes from pre-edge state, then outputs are sampled 1ns after the edge.
    task automatic cycle(output bit enq, output bit deq);
        enq = in_valid && (mq.size() < DEPTH) && !flush;
        deq = out_ready && (mq.size() > 0) && !flush;
        @(posedge clk);
        #1;
        if (flush) mq.delete();
        else begin
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back('{pc: in_pc, inst: in_inst});
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        bit e, d;
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        cycle(e, d);
        in_valid = 1'b0;
    endtask

    initial begin
        bit e, d;
        int nenq, npop, budget;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;

        // 1: reset, then a single enqueue becomes visible the next cycle
        #2;
        check_state("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;
        push(32'h1000, 32'h0000_0013);
        check("t1.out_valid", 64'(out_valid), 64'd1);
        check("t1.out_pc", 64'(out_pc), 64'h1000);
        check("t1.out_inst", 64'(out_inst), 64'h13);
        check("t1.count", 64'(count), 64'd1);
        out_ready = 1'b1;
        cycle(e, d);
        out_ready = 1'b0;
        check_state("t1.drain");

        // 2: fill to DEPTH with out_ready low; head must hold
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h1000 + 32'(4 * i), $urandom);
            check_state("t2.fill");
        end
        check("t2.count_full", 64'(count), 64'(DEPTH));
        check("t2.in_ready_full", 64'(in_ready), 64'd0);
        push(32'h5555_0000, $urandom);
        check("t2.count_after_17th", 64'(count), 64'(DEPTH));
        check_state("t2.reject");

        // 3: full queue with both handshakes: only the dequeue fires
        in_valid = 1'b1; in_pc = 32'h1040; in_inst = $urandom; out_ready = 1'b1;
        cycle(e, d);
        check("t3.count", 64'(count), 64'(DEPTH - 1));
        check("t3.head_pc", 64'(out_pc), 64'h1004);
        out_ready = 1'b0;
        cycle(e, d);
        in_valid = 1'b0;
        check("t3.count_refill", 64'(count), 64'(DEPTH));
        check_state("t3.refill");

        // 4: streaming across two pointer wraps
        flush = 1'b1;
        cycle(e, d);
        flush = 1'b0;
        check_state("t4.flushed");
        nenq = 0; npop = 0; budget = 0;
        out_ready = 1'b1;
        while ((nenq < 40 || mq.size() != 0) && budget < 400) begin
            in_valid = (nenq < 40) && ($urandom_range(0, 3) != 0);
            in_pc    = 32'h1000 + 32'(4 * nenq);
            in_inst  = $urandom;
            if (mq.size() != 0)
                check("t4.pop_order", 64'(out_pc), 64'(32'h1000 + 32'(4 * npop)));
            cycle(e, d);
            if (e) nenq++;
            if (d) npop++;
            check("t4.count_le2", 64'(count <= 2), 64'd1);
            check_state("t4.stream");
            budget++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("t4.popped", 64'(npop), 64'd40);

        // 5: flush with traffic in the same cycle
        for (int i = 0; i < 5; i++) push(32'h3000_0000 + 32'(i), $urandom);
        check("t5.count5", 64'(count), 64'd5);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD_0000; in_inst = $urandom; out_ready = 1'b1;
        cycle(e, d);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t5.count", 64'(count), 64'd0);
        check("t5.out_valid", 64'(out_valid), 64'd0);
        check("t5.in_ready", 64'(in_ready), 64'd1);
        push(32'h3000, 32'h0000_0093);
        check("t5.next_pc", 64'(out_pc), 64'h3000);

        // 6: asynchronous reset between edges
        flush = 1'b1; cycle(e, d); flush = 1'b0;
        for (int i = 0; i < 7; i++) push(32'h4000 + 32'(4 * i), $urandom);
        check("t6.count7", 64'(count), 64'd7);
        #2 rst = 1'b1;
        #1;
        mq.delete();
        check("t6.async_count", 64'(count), 64'd0);
        check("t6.async_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(32'h2000, 32'h0000_0033);
        check("t6.out_pc", 64'(out_pc), 64'h2000);
        check_state("t6.after");

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_pc     = $urandom;
            in_inst   = $urandom;
            cycle(e, d);
            check_state("rand");
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
